coproc_arbiter: RTL and testbench
=================================

Name: coproc_arbiter

Overview:
- Shares one coprocessor compute module (mstart/min → mrdy/mout handshake) between NREQ independent requesters, e.g. several bus-side coprocessor front-ends.
- Buffers one pending command per requester and grants the module round-robin.
- Issues a single-cycle start, waits for completion, then routes the result back to the owning requester.
- Sits between the front-end decoders and the shared compute module.

Parameters:
- NREQ, 4, number of requesters (2..4).
- IDW, 2, width of requester index; 2^IDW >= NREQ.
- DW, 24, command/result data width.
- TIMEOUT, 1023, cycles allowed in WAIT before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_start  in  NREQ  per-requester one-cycle command strobe.
- req_data  in  NREQ*DW  per-requester command; slice i = [i*DW +: DW].
- req_pend  out  NREQ  slot i holds an unserved or in-flight command.
- resp_valid  out  NREQ  one-cycle result strobe to requester i.
- resp_data  out  DW  result data, valid with any resp_valid bit.
- resp_err  out  1  result aborted by timeout; qualifies resp_valid.
- mstart  out  1  one-cycle start to the compute module.
- min  out  DW  command to the module; held stable from ISSUE until leaving WAIT.
- mrdy  in  1  module completion strobe.
- mout  in  DW  module result, valid with mrdy.
- owner  out  IDW  index of the current or last granted requester.
- busy  out  1  state != IDLE.
- ovf  out  NREQ  sticky: req_start arrived while slot i was pending.
- spur  out  1  sticky: mrdy seen outside WAIT.
- clr  in  1  synchronous clear of ovf and spur.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including req_pend, resp_valid, resp_data, resp_err, min, owner, ovf and spur.
- All outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Slots:
- req_start[i] with slot empty: latch req_data slice i; req_pend[i]=1 from the next cycle.
- req_start[i] with slot full: command discarded, slot unchanged, ovf[i] set.
- A slot clears on the edge where its result is delivered.
- req_start[i] in that same cycle is accepted as a new command: it is not counted as overflow, and the new data is kept.

FSM:
- IDLE: if any slot pending, pick the first pending index after owner, searching owner+1, owner+2, ... with wrap modulo NREQ.
  - Register owner and min = slot data; go to ISSUE.
  - With owner=0 after reset, requester 1 has first priority.
  - A slot is only eligible if pending at the start of the cycle.
- ISSUE: mstart=1 for exactly this cycle; go to WAIT.
- WAIT: on mrdy, go to IDLE and, on the same edge:
  - resp_valid[owner]=1 for one cycle;
  - resp_data=mout;
  - resp_err=0;
  - clear slot owner.
  - resp_data holds until the next delivery.
- Timing:
  - req_start in cycle t → mstart in cycle t+2 when idle.
  - mrdy in cycle k → resp_valid in cycle k+1.
  - The next mstart is no earlier than k+2, giving one IDLE cycle between jobs.
- mrdy in IDLE or ISSUE is ignored for data and sets spur. mout is ignored without mrdy.
- If clr and a set event occur in the same cycle, the set wins.
- Reset mid-job: everything returns to reset values; the in-flight result is lost, and a late mrdy after reset sets spur.

Optional Feature:
Macro COPROC_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT with no mrdy, go to IDLE and deliver resp_valid[owner] with resp_err=1 and resp_data=0; the slot clears.
  - mrdy in the same cycle as the timeout wins: normal delivery.
- Undefined: no counter, WAIT lasts indefinitely, resp_err is tied 0.

Test Plan:
- Single request: after reset, req_start[2] with data 0x00ABCD, module returns mrdy with mout 0x123456 three cycles after mstart → mstart in t+2 with min=0x00ABCD; resp_valid=4'b0100 and resp_data=0x123456 one cycle after mrdy; req_pend[2] falls then.
- Round-robin: requesters 0..3 strobe in the same cycle after reset → grant order 1,2,3,0; each gets its own data back; no ovf.
- Overflow and refill:
  - A second req_start[0] while slot 0 pending → ovf=4'b0001, original data served.
  - req_start[0] in the delivery cycle → accepted, second job issued, ovf unchanged.
- Spurious completion: mrdy while IDLE → spur=1, no resp_valid; clr → spur=0.
- Reset mid-WAIT: rst low for 1 cycle while WAIT → all outputs 0, busy=0; later mrdy sets spur only.
- With COPROC_ARB_TIMEOUT_EN, TIMEOUT=8, module never answers → resp_valid with resp_err=1 and resp_data=0 after 8 WAIT cycles; next pending requester then issued.

Source files
------------

// File: rtl/coproc_arbiter.sv
// Round-robin arbiter sharing one coprocessor compute module between NREQ requesters.
// Optional WAIT-state abort is enabled by defining COPROC_ARB_TIMEOUT_EN.
module coproc_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int DW      = 24,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_start,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_pend,
  output logic [NREQ-1:0]     resp_valid,
  output logic [DW-1:0]       resp_data,
  output logic                resp_err,
  output logic                mstart,
  output logic [DW-1:0]       min,
  input  logic                mrdy,
  input  logic [DW-1:0]       mout,
  output logic [IDW-1:0]      owner,
  output logic                busy,
  output logic [NREQ-1:0]     ovf,
  output logic                spur,
  input  logic                clr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  if (NREQ < 2 || NREQ > 4 || (1 << IDW) < NREQ || TIMEOUT < 1) begin : g_bad_cfg
    $error("coproc_arbiter: unsupported parameter combination");
  end

  logic [1:0]      r_state;
  logic [NREQ-1:0] r_pend;
  logic [NREQ-1:0] r_ovf;
  logic [NREQ-1:0] r_resp_valid;
  logic [DW-1:0]   r_slot [NREQ];
  logic [DW-1:0]   r_min;
  logic [DW-1:0]   r_resp_data;
  logic [IDW-1:0]  r_owner;
  logic            r_spur;

  logic            w_tmo;
  logic            w_deliver;
  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [IDW-1:0]  w_pick;
  logic [NREQ-1:0] w_free;

  assign w_deliver = (r_state == S_WAIT) && (mrdy || w_tmo);

  // Search owner+1, owner+2, ... wrapping; first pending slot wins.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      w_idx = IDW'((32'(r_owner) + k) % NREQ);
      if (!w_found && r_pend[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_free = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_free[i] = w_deliver && (r_owner == IDW'(i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_min   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_pick;
            r_min   <= r_slot[w_pick];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT:  if (w_deliver) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A slot being freed on this edge may be refilled on the same edge without overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend <= '0;
      r_ovf  <= '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
        r_slot[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_start[i] && (!r_pend[i] || w_free[i])) begin
          r_slot[i] <= req_data[i*DW +: DW];
          r_pend[i] <= 1'b1;
        end else if (w_free[i]) begin
          r_pend[i] <= 1'b0;
        end
        if (req_start[i] && r_pend[i] && !w_free[i]) begin
          r_ovf[i] <= 1'b1;
        end else if (clr) begin
          r_ovf[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_resp_valid <= '0;
      r_resp_data  <= '0;
      r_spur       <= 1'b0;
    end else begin
      r_resp_valid <= w_free;
      if (w_deliver) begin
        r_resp_data <= w_tmo ? '0 : mout;
      end
      if (mrdy && (r_state != S_WAIT)) begin
        r_spur <= 1'b1;
      end else if (clr) begin
        r_spur <= 1'b0;
      end
    end
  end

`ifdef COPROC_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_tcnt;
  logic          r_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_tcnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tcnt <= r_tcnt + 1'b1;
      end
      r_err <= w_deliver && w_tmo;
    end
  end

  assign w_tmo    = (r_state == S_WAIT) && !mrdy && (r_tcnt == TW'(TIMEOUT - 1));
  assign resp_err = r_err;
`else
  assign w_tmo    = 1'b0;
  assign resp_err = 1'b0;
`endif

  assign req_pend   = r_pend;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign mstart     = (r_state == S_ISSUE);
  assign min        = r_min;
  assign owner      = r_owner;
  assign busy       = (r_state != S_IDLE);
  assign ovf        = r_ovf;
  assign spur       = r_spur;

endmodule

// File: tb/tb_coproc_arbiter.sv
// Bench for coproc_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model of slots, round-robin grants and the shared module.
module tb_coproc_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int DW   = 24;
  localparam int TMO  = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req_start = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]    req_pend;
  logic [NREQ-1:0]    resp_valid;
  logic [DW-1:0]      resp_data;
  logic               resp_err;
  logic               mstart;
  logic [DW-1:0]      min;
  logic               mrdy = 1'b0;
  logic [DW-1:0]      mout = '0;
  logic [IDW-1:0]     owner;
  logic               busy;
  logic [NREQ-1:0]    ovf;
  logic               spur;
  logic               clr = 1'b0;

  always #5 clk = ~clk;

  coproc_arbiter #(.NREQ(NREQ), .IDW(IDW), .DW(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .req_start(req_start), .req_data(req_data),
    .req_pend(req_pend), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .mstart(mstart), .min(min), .mrdy(mrdy), .mout(mout),
    .owner(owner), .busy(busy), .ovf(ovf), .spur(spur), .clr(clr)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-requester mailbox, one job in flight at most.
  logic [DW-1:0]   m_data [NREQ];
  bit   [NREQ-1:0] m_pend, m_ovf, m_rv;
  bit              m_spur, m_err, m_started;
  logic [DW-1:0]   m_rd, m_min;
  int              m_owner, m_job, m_wcnt;

  function automatic logic [DW-1:0] fmod(input logic [DW-1:0] x);
    return {x[11:0], x[23:12]} ^ 24'h5A3C96;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREQ; i++) m_data[i] = '0;
    m_pend = '0; m_ovf = '0; m_rv = '0;
    m_spur = 0; m_err = 0; m_started = 0;
    m_rd = '0; m_min = '0; m_owner = 0; m_job = -1; m_wcnt = 0;
  endtask

  task automatic model_step();
    bit waiting, tmo, deliver, found, set;
    int fr, c;
    waiting = (m_job >= 0) && m_started;
    tmo = 0;
`ifdef COPROC_ARB_TIMEOUT_EN
    tmo = waiting && !mrdy && (m_wcnt == TMO - 1);
`endif
    deliver = waiting && (mrdy || tmo);
    fr = deliver ? m_job : -1;
    if (mrdy && !waiting) m_spur = 1;
    else if (clr) m_spur = 0;
    m_rv = '0;
    m_err = 0;
    if (deliver) begin
      m_rv[m_job] = 1'b1;
      m_rd = tmo ? '0 : mout;
      m_err = tmo;
    end
    if (deliver) m_job = -1;
    else if (m_job >= 0 && !m_started) begin m_started = 1; m_wcnt = 0; end
    else if (waiting) m_wcnt++;
    else begin
      found = 0;
      for (int k = 1; k <= NREQ; k++) begin
        c = (m_owner + k) % NREQ;
        if (!found && m_pend[c]) begin
          found = 1; m_owner = c; m_min = m_data[c]; m_job = c; m_started = 0;
        end
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      set = 0;
      if (req_start[i]) begin
        if (!m_pend[i] || fr == i) begin
          m_data[i] = req_data[i*DW +: DW];
          m_pend[i] = 1'b1;
        end else set = 1;
      end else if (fr == i) m_pend[i] = 1'b0;
      if (set) m_ovf[i] = 1'b1;
      else if (clr) m_ovf[i] = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("req_pend",   req_pend,   m_pend);
    check("resp_valid", resp_valid, m_rv);
    check("resp_data",  resp_data,  m_rd);
    check("resp_err",   resp_err,   m_err);
    check("mstart",     mstart,     (m_job >= 0) && !m_started);
    check("min",        min,        m_min);
    check("owner",      owner,      m_owner);
    check("busy",       busy,       m_job >= 0);
    check("ovf",        ovf,        m_ovf);
    check("spur",       spur,       m_spur);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    req_start = '0; mrdy = 1'b0; clr = 1'b0;
    mout = DW'($urandom);
    req_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_all();
    rst = 1'b1;
  endtask

  logic [DW-1:0] rr_dat [NREQ];
  int            rr_order [NREQ];
  bit            resp_pend;
  int            dly;

  initial begin
    do_reset();

    // Single request, module answers three cycles after mstart
    req_start = 4'b0100; req_data[2*DW +: DW] = 24'h00ABCD;
    step();
    check("t1_pend", req_pend, 4'b0100);
    idle_inputs(); step();
    check("t1_mstart", mstart, 1); check("t1_min", min, 24'h00ABCD);
    step(); step(); step();
    mrdy = 1'b1; mout = 24'h123456; step();
    check("t1_rv", resp_valid, 4'b0100);
    check("t1_rd", resp_data, 24'h123456);
    check("t1_pend_clr", req_pend, 4'b0000);
    idle_inputs(); step();

    // Round-robin from reset: 1,2,3,0
    do_reset();
    rr_order = '{1, 2, 3, 0};
    req_start = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      rr_dat[i] = DW'(24'h100000 * (i + 1) + 24'h0000A5 + i);
      req_data[i*DW +: DW] = rr_dat[i];
    end
    step();
    idle_inputs(); step();
    for (int j = 0; j < NREQ; j++) begin
      check("rr_mstart", mstart, 1);
      check("rr_owner", owner, rr_order[j]);
      check("rr_min", min, rr_dat[rr_order[j]]);
      step();
      mrdy = 1'b1; mout = fmod(rr_dat[rr_order[j]]); step();
      check("rr_rv", resp_valid, 32'(1) << rr_order[j]);
      check("rr_rd", resp_data, fmod(rr_dat[rr_order[j]]));
      idle_inputs(); step();
    end
    check("rr_ovf", ovf, 0);

    // Overflow, then refill in the delivery cycle
    do_reset();
    req_start = 4'b0001; req_data[0 +: DW] = 24'h111111; step();
    idle_inputs(); req_start = 4'b0001; req_data[0 +: DW] = 24'h222222; step();
    check("ovf_set", ovf, 4'b0001);
    check("ovf_min", min, 24'h111111);
    idle_inputs(); step();
    mrdy = 1'b1; mout = fmod(24'h111111);
    req_start = 4'b0001; req_data[0 +: DW] = 24'h333333; step();
    check("refill_rv", resp_valid, 4'b0001);
    check("refill_rd", resp_data, fmod(24'h111111));
    check("refill_pend", req_pend, 4'b0001);
    check("refill_ovf", ovf, 4'b0001);
    idle_inputs(); step();
    check("refill_mstart", mstart, 1);
    check("refill_min", min, 24'h333333);
    step();
    mrdy = 1'b1; mout = fmod(24'h333333); step();
    idle_inputs(); step();

    // Spurious completion, clear, and set-beats-clear
    mrdy = 1'b1; step();
    check("spur_set", spur, 1); check("spur_rv", resp_valid, 0);
    idle_inputs(); clr = 1'b1; step();
    check("spur_clr", spur, 0); check("ovf_clr", ovf, 0);
    idle_inputs(); mrdy = 1'b1; clr = 1'b1; step();
    check("spur_win", spur, 1);
    idle_inputs(); clr = 1'b1; step();
    idle_inputs();

    // Reset while waiting on the module
    req_start = 4'b1000; req_data[3*DW +: DW] = 24'h0F0F0F; step();
    idle_inputs(); step(); step();
    check("mid_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("mid_pend", req_pend, 0); check("mid_busy0", busy, 0);
    check("mid_min", min, 0);       check("mid_owner", owner, 0);
    check("mid_mstart", mstart, 0); check("mid_rd", resp_data, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    compare_all();
    mrdy = 1'b1; mout = 24'h777777; step();
    check("late_spur", spur, 1); check("late_rv", resp_valid, 0);
    check("late_rd", resp_data, 0);
    idle_inputs(); clr = 1'b1; step();

`ifdef COPROC_ARB_TIMEOUT_EN
    // Module never answers: abort after TMO WAIT cycles, then next requester
    do_reset();
    req_start = 4'b0110; step();
    idle_inputs(); step();
    check("tmo_owner", owner, 1);
    for (int i = 0; i < TMO + 1; i++) begin idle_inputs(); step(); end
    check("tmo_rv", resp_valid, 4'b0010);
    check("tmo_err", resp_err, 1);
    check("tmo_rd", resp_data, 0);
    idle_inputs(); step();
    check("tmo_next", mstart, 1); check("tmo_next_owner", owner, 2);
    step(); mrdy = 1'b1; mout = fmod(min); step();
    idle_inputs(); step();
`endif

    // Randomized traffic with a responder of variable latency
    do_reset();
    resp_pend = 0; dly = 0;
    for (int c = 0; c < 1500; c++) begin
      idle_inputs();
      for (int i = 0; i < NREQ; i++) req_start[i] = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 29) == 0);
      if (resp_pend) begin
        if (dly == 0) begin mrdy = 1'b1; mout = fmod(m_min); resp_pend = 0; end
        else dly--;
      end else if (m_job < 0 && $urandom_range(0, 39) == 0) begin
        mrdy = 1'b1;
      end
      step();
      if (m_job >= 0 && !m_started) begin resp_pend = 1; dly = $urandom_range(0, 3); end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
